// File: rtl/ram_result_checker_pkg.sv
// ram_check_pkg: widths, sweep depth and FSM states shared by the RAM result checker
package ram_check_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH = 512;
  localparam int TOT_W = ADDR_W + DATA_W;
  localparam int ERR_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/ram_result_checker_if.sv
// ram_result_checker_if: start/RAM read port/result bundle between the checker and its surroundings
interface ram_result_checker_if;
  import ram_check_pkg::*;
  logic              start_i;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] sum_data_i;
  logic [DATA_W-1:0] diff_data_i;
  logic              busy_o;
  logic              done_o;
  logic [TOT_W-1:0]  sum_total_o;
  logic [ERR_W-1:0]  parity_err_o;
  logic [DATA_W-1:0] max_sum_o;
  logic [ADDR_W-1:0] max_addr_o;
  modport slave(
    input start_i, sum_data_i, diff_data_i,
    output ram_addr_o, busy_o, done_o, sum_total_o, parity_err_o, max_sum_o, max_addr_o
  );
  modport master(
    output start_i, sum_data_i, diff_data_i,
    input ram_addr_o, busy_o, done_o, sum_total_o, parity_err_o, max_sum_o, max_addr_o
  );
endinterface

// File: rtl/ram_result_checker_accumulator.sv
// result_accumulator: running total, LSB parity mismatch count and first-maximum tracking
module result_accumulator
  import ram_check_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clr,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_sum,
  input  logic [DATA_W-1:0] i_diff,
  output logic [TOT_W-1:0]  o_total,
  output logic [ERR_W-1:0]  o_perr,
  output logic [DATA_W-1:0] o_max_sum,
  output logic [ADDR_W-1:0] o_max_addr
);
  logic [TOT_W-1:0]  r_total;
  logic [ERR_W-1:0]  r_perr;
  logic [DATA_W-1:0] r_max_sum;
  logic [ADDR_W-1:0] r_max_addr;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn || i_clr) begin
      r_total    <= '0;
      r_perr     <= '0;
      r_max_sum  <= '0;
      r_max_addr <= '0;
    end else if (i_vld) begin
      r_total <= r_total + TOT_W'(i_sum);
      r_perr  <= r_perr + ERR_W'(i_sum[0] ^ i_diff[0]);
      // strict compare keeps the lowest address on ties
      if (i_sum > r_max_sum) begin
        r_max_sum  <= i_sum;
        r_max_addr <= i_addr;
      end
    end
  assign o_total    = r_total;
  assign o_perr     = r_perr;
  assign o_max_sum  = r_max_sum;
  assign o_max_addr = r_max_addr;
endmodule

// File: rtl/ram_result_checker.sv
// ram_result_checker: sweeps both RAMs once per start and reports sum total, parity errors and max
module ram_result_checker
  import ram_check_pkg::*;
(
  input logic CLOCK_50_I,
  input logic resetn,
  ram_result_checker_if.slave bus
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr_d;
  logic              r_vld;
  logic              r_busy;
  logic              r_done;
  logic              w_go;
  // the idle cycle carrying done_o is skipped so a held start re-runs one cycle later
  assign w_go = r_state == S_IDLE && bus.start_i && !r_done;
  always_ff @(posedge CLOCK_50_I or negedge resetn)
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_addr_d <= '0;
      r_vld    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_vld  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_go) begin
          r_state <= S_READ;
          r_busy  <= 1'b1;
          r_addr  <= '0;
        end
        S_READ: begin
          r_vld    <= 1'b1;
          r_addr_d <= r_addr;
          if (r_addr == LAST_ADDR) r_state <= S_DRAIN;
          else r_addr <= r_addr + 1'b1;
        end
        S_DRAIN: r_state <= S_DONE;
        default: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  result_accumulator u_acc (
    .i_clk      (CLOCK_50_I),
    .i_rstn     (resetn),
    .i_clr      (w_go),
    .i_vld      (r_vld),
    .i_addr     (r_addr_d),
    .i_sum      (bus.sum_data_i),
    .i_diff     (bus.diff_data_i),
    .o_total    (bus.sum_total_o),
    .o_perr     (bus.parity_err_o),
    .o_max_sum  (bus.max_sum_o),
    .o_max_addr (bus.max_addr_o)
  );
  assign bus.ram_addr_o = r_addr;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
endmodule

// File: tb/tb_ram_result_checker.sv
// tb_ram_result_checker: directed runs against 1-cycle RAM models, scoreboard checks each done_o
module tb_ram_result_checker;
  import ram_check_pkg::*;
  typedef struct {
    int total;
    int perr;
    int max_sum;
    int max_addr;
    int gap;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [DATA_W-1:0] m0 [DEPTH];
  logic [DATA_W-1:0] m1 [DEPTH];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int last_done = 0;
  int n_done = 0;
  logic pb = 1'b0;
  logic pd = 1'b0;
  ram_result_checker_if bus();
  ram_result_checker dut (.CLOCK_50_I(clk), .resetn(resetn), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    bus.sum_data_i  <= m0[bus.ram_addr_o];
    bus.diff_data_i <= m1[bus.ram_addr_o];
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy_o && !pb) t0 = cyc;
    pb = bus.busy_o;
    if (bus.done_o) begin
      n_done++;
      chk("done_width", int'(pd), 0);
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("run_length", cyc - t0, 514);
        chk("sum_total", int'(bus.sum_total_o), e.total);
        chk("parity_err", int'(bus.parity_err_o), e.perr);
        chk("max_sum", int'(bus.max_sum_o), e.max_sum);
        chk("max_addr", int'(bus.max_addr_o), e.max_addr);
        chk("busy_at_done", int'(bus.busy_o), 0);
        if (e.gap != 0) chk("done_gap", cyc - last_done, e.gap);
      end
      last_done = cyc;
    end
    pd = bus.done_o;
  end
  task automatic load(input int p);
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = (p == 0) ? 8'd0 : (p == 1) ? 8'(i) : 8'hFF;
      m1[i] = (p == 0) ? 8'd0 : (p == 1) ? 8'(i) : (i < 10) ? 8'hFE : 8'hFF;
    end
  endtask
  task automatic push(input int total, input int perr, input int ms, input int ma, input int gap);
    exp_t e;
    e.total = total;
    e.perr = perr;
    e.max_sum = ms;
    e.max_addr = ma;
    e.gap = gap;
    q.push_back(e);
  endtask
  task automatic pulse_start();
    @(negedge clk) bus.start_i = 1'b1;
    @(negedge clk) bus.start_i = 1'b0;
  endtask
  task automatic wait_empty(input int lim);
    int i;
    for (i = 0; i < lim && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("timeout_pending", q.size(), 0);
    repeat (4) @(negedge clk);
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, int'(bus.busy_o), 0);
    chk({tag, "_done"}, int'(bus.done_o), 0);
    chk({tag, "_addr"}, int'(bus.ram_addr_o), 0);
    chk({tag, "_total"}, int'(bus.sum_total_o), 0);
    chk({tag, "_perr"}, int'(bus.parity_err_o), 0);
    chk({tag, "_max_sum"}, int'(bus.max_sum_o), 0);
    chk({tag, "_max_addr"}, int'(bus.max_addr_o), 0);
  endtask
  initial begin
    int base;
    bus.start_i = 1'b0;
    load(0);
    #35;
    chk_cleared("reset");
    @(negedge clk) resetn = 1'b1;
    repeat (3) @(negedge clk);
    push(0, 0, 0, 0, 0);
    pulse_start();
    wait_empty(700);
    load(1);
    push(65280, 0, 255, 255, 0);
    pulse_start();
    wait_empty(700);
    load(2);
    push(130560, 10, 255, 0, 0);
    pulse_start();
    wait_empty(700);
    #7 resetn = 1'b0;
    #1 chk_cleared("async_reset");
    @(negedge clk) resetn = 1'b1;
    load(1);
    push(65280, 0, 255, 255, 0);
    pulse_start();
    repeat (48) @(negedge clk);
    pulse_start();
    repeat (248) @(negedge clk);
    pulse_start();
    wait_empty(700);
    repeat (20) @(negedge clk);
    load(2);
    base = n_done;
    push(130560, 10, 255, 0, 0);
    push(130560, 10, 255, 0, 516);
    push(130560, 10, 255, 0, 516);
    @(negedge clk) bus.start_i = 1'b1;
    for (int i = 0; i < 1200 && n_done < base + 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    bus.start_i = 1'b0;
    wait_empty(700);
    load(1);
    pulse_start();
    repeat (198) @(negedge clk);
    #3 resetn = 1'b0;
    #1 chk_cleared("mid_run_reset");
    @(negedge clk) resetn = 1'b1;
    push(65280, 0, 255, 255, 0);
    pulse_start();
    wait_empty(700);
    repeat (20) @(negedge clk);
    chk("leftover_expected", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
